bomb_sequencer: RTL and testbench



---
 rtl/bomb_sequencer_if.sv | 34 +++
 rtl/bomb_sequencer.sv | 228 ++++++++++++++++++++++
 tb/tb_bomb_sequencer.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/bomb_sequencer_if.sv
// Bomb sequencer bus: key-decode inputs, block-map write handshake and status outputs.
interface bomb_sequencer_if;
    localparam int unsigned COL_W  = 6;
    localparam int unsigned ROW_W  = 5;
    localparam int unsigned ADDR_W = 10;

    logic              place_req;
    logic [COL_W-1:0]  bm_col;
    logic [ROW_W-1:0]  bm_row;
    logic              blk_wr_gnt;
    logic              bomb_active;
    logic [COL_W-1:0]  bomb_col;
    logic [ROW_W-1:0]  bomb_row;
    logic              exp_active;
    logic              exp_start;
    logic              post_exp_active;
    logic              blk_we;
    logic [ADDR_W-1:0] blk_w_addr;
    logic              busy;

    // Sequencer side
    modport master (
        input  place_req, bm_col, bm_row, blk_wr_gnt,
        output bomb_active, bomb_col, bomb_row, exp_active, exp_start,
               post_exp_active, blk_we, blk_w_addr, busy
    );

    // Arena side (key decode, sprites, block map)
    modport slave (
        output place_req, bm_col, bm_row, blk_wr_gnt,
        input  bomb_active, bomb_col, bomb_row, exp_active, exp_start,
               post_exp_active, blk_we, blk_w_addr, busy
    );
endinterface

// File: rtl/bomb_sequencer.sv
// Single-bomb life cycle: place, fuse, tile clear over the block-map write port,
// explosion display, post-explosion lockout.
module bomb_sequencer #(
    parameter int unsigned ARENA_COLS  = 33,
    parameter int unsigned ARENA_ROWS  = 27,
    parameter int unsigned FUSE_CYCLES = 150000000,
    parameter int unsigned EXP_CYCLES  = 50000000,
    parameter int unsigned POST_CYCLES = 25000000,
    parameter int unsigned CNT_W       = 28
) (
    input  logic                  clk,
    input  logic                  reset,
    bomb_sequencer_if.master      bus
);

    localparam int unsigned COL_W  = 6;
    localparam int unsigned ROW_W  = 5;
    localparam int unsigned CX_W   = COL_W + 1;
    localparam int unsigned RX_W   = ROW_W + 1;
    localparam int unsigned ADDR_W = 10;
    localparam int unsigned IDX_W  = 3;
    localparam int unsigned NTGT   = 8;

    // Target order: 0 center, 1 up, 2 right, 3 down, 4 left; 5..7 never valid
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FUSE    = 3'd1,
        S_CLEAR   = 3'd2,
        S_EXPLODE = 3'd3,
        S_POST    = 3'd4
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [COL_W-1:0]    bomb_col_q, bomb_col_d;
    logic [ROW_W-1:0]    bomb_row_q, bomb_row_d;
    logic [IDX_W-1:0]    tgt_idx_q, tgt_idx_d;
    logic [ADDR_W-1:0]   blk_w_addr_q, blk_w_addr_d;
    logic                blk_we_q, blk_we_d;
    logic                exp_start_q, exp_start_d;
    logic                bomb_active_q, bomb_active_d;
    logic                exp_active_q, exp_active_d;
    logic                post_exp_active_q, post_exp_active_d;
    logic                busy_q, busy_d;

    logic [NTGT-1:0]     tgt_valid;
    logic [ADDR_W-1:0]   tgt_addr [NTGT];
    logic [CX_W-1:0]     col_x;
    logic [RX_W-1:0]     row_x;
    logic                first_found;
    logic [IDX_W-1:0]    first_idx;
    logic                nxt_found;
    logic [IDX_W-1:0]    nxt_idx;

    function automatic logic col_ok(input logic [CX_W-1:0] c);
        return c < CX_W'(ARENA_COLS);
    endfunction

    function automatic logic row_ok(input logic [RX_W-1:0] r);
        return r < RX_W'(ARENA_ROWS);
    endfunction

    function automatic logic [ADDR_W-1:0] addr_of(input logic [CX_W-1:0] c,
                                                  input logic [RX_W-1:0] r);
        return ADDR_W'(r) * ADDR_W'(ARENA_COLS) + ADDR_W'(c);
    endfunction

    // Cross geometry around the latched bomb tile; up/left guarded before subtracting
    always_comb begin
        tgt_valid = '0;
        for (int i = 0; i < int'(NTGT); i++) begin
            tgt_addr[i] = '0;
        end
        col_x = {1'b0, bomb_col_q};
        row_x = {1'b0, bomb_row_q};

        tgt_valid[0] = col_ok(col_x) && row_ok(row_x);
        tgt_addr[0]  = addr_of(col_x, row_x);

        tgt_valid[1] = (bomb_row_q != '0) && col_ok(col_x) && row_ok(row_x - RX_W'(1));
        tgt_addr[1]  = addr_of(col_x, row_x - RX_W'(1));

        tgt_valid[2] = col_ok(col_x + CX_W'(1)) && row_ok(row_x);
        tgt_addr[2]  = addr_of(col_x + CX_W'(1), row_x);

        tgt_valid[3] = col_ok(col_x) && row_ok(row_x + RX_W'(1));
        tgt_addr[3]  = addr_of(col_x, row_x + RX_W'(1));

        tgt_valid[4] = (bomb_col_q != '0) && col_ok(col_x - CX_W'(1)) && row_ok(row_x);
        tgt_addr[4]  = addr_of(col_x - CX_W'(1), row_x);
    end

    // First valid target, and next valid target after the one being written
    always_comb begin
        first_found = 1'b0;
        first_idx   = '0;
        nxt_found   = 1'b0;
        nxt_idx     = '0;
        for (int j = int'(NTGT) - 1; j >= 0; j--) begin
            if (tgt_valid[j]) begin
                first_found = 1'b1;
                first_idx   = IDX_W'(j);
            end
            if (tgt_valid[j] && (j > int'(tgt_idx_q))) begin
                nxt_found = 1'b1;
                nxt_idx   = IDX_W'(j);
            end
        end
    end

    // Next-state, counter and registered-output computation
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bomb_col_d   = bomb_col_q;
        bomb_row_d   = bomb_row_q;
        tgt_idx_d    = tgt_idx_q;
        blk_w_addr_d = blk_w_addr_q;
        blk_we_d     = 1'b0;
        exp_start_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.place_req) begin
                    bomb_col_d = bus.bm_col;
                    bomb_row_d = bus.bm_row;
                    cnt_d      = CNT_W'(FUSE_CYCLES - 1);
                    state_d    = S_FUSE;
                end
            end
            S_FUSE: begin
                if (cnt_q == '0) begin
                    exp_start_d = 1'b1;
                    if (first_found) begin
                        tgt_idx_d    = first_idx;
                        blk_w_addr_d = tgt_addr[first_idx];
                        blk_we_d     = 1'b1;
                        state_d      = S_CLEAR;
                    end else begin
                        cnt_d   = CNT_W'(EXP_CYCLES - 1);
                        state_d = S_EXPLODE;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_CLEAR: begin
                // Request and address hold until a grant completes the write
                blk_we_d = 1'b1;
                if (bus.blk_wr_gnt) begin
                    if (nxt_found) begin
                        tgt_idx_d    = nxt_idx;
                        blk_w_addr_d = tgt_addr[nxt_idx];
                    end else begin
                        blk_we_d = 1'b0;
                        cnt_d    = CNT_W'(EXP_CYCLES - 1);
                        state_d  = S_EXPLODE;
                    end
                end
            end
            S_EXPLODE: begin
                if (cnt_q == '0) begin
                    cnt_d   = CNT_W'(POST_CYCLES - 1);
                    state_d = S_POST;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_POST: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        bomb_active_d     = (state_d == S_FUSE);
        exp_active_d      = (state_d == S_CLEAR) || (state_d == S_EXPLODE);
        post_exp_active_d = (state_d == S_POST);
        busy_d            = (state_d != S_IDLE);
    end

    // State and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q           <= S_IDLE;
            cnt_q             <= '0;
            bomb_col_q        <= '0;
            bomb_row_q        <= '0;
            tgt_idx_q         <= '0;
            blk_w_addr_q      <= '0;
            blk_we_q          <= 1'b0;
            exp_start_q       <= 1'b0;
            bomb_active_q     <= 1'b0;
            exp_active_q      <= 1'b0;
            post_exp_active_q <= 1'b0;
            busy_q            <= 1'b0;
        end else begin
            state_q           <= state_d;
            cnt_q             <= cnt_d;
            bomb_col_q        <= bomb_col_d;
            bomb_row_q        <= bomb_row_d;
            tgt_idx_q         <= tgt_idx_d;
            blk_w_addr_q      <= blk_w_addr_d;
            blk_we_q          <= blk_we_d;
            exp_start_q       <= exp_start_d;
            bomb_active_q     <= bomb_active_d;
            exp_active_q      <= exp_active_d;
            post_exp_active_q <= post_exp_active_d;
            busy_q            <= busy_d;
        end
    end

    assign bus.bomb_active     = bomb_active_q;
    assign bus.bomb_col        = bomb_col_q;
    assign bus.bomb_row        = bomb_row_q;
    assign bus.exp_active      = exp_active_q;
    assign bus.exp_start       = exp_start_q;
    assign bus.post_exp_active = post_exp_active_q;
    assign bus.blk_we          = blk_we_q;
    assign bus.blk_w_addr      = blk_w_addr_q;
    assign bus.busy            = busy_q;

endmodule

// File: tb/tb_bomb_sequencer.sv
// Bench for bomb_sequencer: directed corner bombs plus randomized bombs, grant
// stalls and stray place requests, scored against a transaction-level model.
module tb_bomb_sequencer;

    localparam int COLS = 33;
    localparam int ROWS = 27;
    localparam int FUSE = 8;
    localparam int EXP  = 4;
    localparam int POST = 3;
    localparam int LOOP_BUDGET = 500;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    bomb_sequencer_if bus();

    bomb_sequencer #(
        .ARENA_COLS (COLS),
        .ARENA_ROWS (ROWS),
        .FUSE_CYCLES(FUSE),
        .EXP_CYCLES (EXP),
        .POST_CYCLES(POST),
        .CNT_W      (28)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    int exp_q[$];

    // Count one comparison and report it if it differs
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    // Expected write addresses: the cross around (c,r), clipped to the arena
    function automatic void build_expected(input int c, input int r);
        int dc[5];
        int dr[5];
        int tc;
        int tr;
        dc = '{0, 0, 1, 0, -1};
        dr = '{0, -1, 0, 1, 0};
        exp_q.delete();
        for (int k = 0; k < 5; k++) begin
            tc = c + dc[k];
            tr = r + dr[k];
            if (tc >= 0 && tc < COLS && tr >= 0 && tr < ROWS)
                exp_q.push_back(tr * COLS + tc);
        end
    endfunction

    // gmode: 0 grant always, 1 ten-cycle stall at first write, 2 random grant
    // hmode: 0 quiet, 1 place_req every busy cycle, 2 random place_req
    task automatic run_bomb(input int c, input int r, input int gmode, input int hmode);
        int bomb_cyc = 0;
        int exp_cyc = 0;
        int post_cyc = 0;
        int starts = 0;
        int stalls = 0;
        int stall_left;
        int cyc = 0;
        int got_q[$];
        logic prev_stall = 1'b0;
        logic [9:0] prev_addr = '0;
        logic gnt;

        build_expected(c, r);
        chk("idle_before", bus.busy, 0);
        bus.bm_col     = 6'(c);
        bus.bm_row     = 5'(r);
        bus.place_req  = 1'b1;
        bus.blk_wr_gnt = 1'b1;
        @(negedge clk);
        bus.place_req = 1'b0;
        stall_left = (gmode == 1) ? 10 : 0;

        while (bus.busy === 1'b1 && cyc < LOOP_BUDGET) begin
            cyc++;
            if (bus.bomb_active) begin
                bomb_cyc++;
                chk("bomb_col", bus.bomb_col, c);
                chk("bomb_row", bus.bomb_row, r);
            end
            if (bus.exp_active) exp_cyc++;
            if (bus.post_exp_active) post_cyc++;
            if (bus.exp_start) begin
                starts++;
                chk("start_with_exp", bus.exp_active, 1);
                chk("start_after_fuse", bomb_cyc, FUSE);
            end
            chk("one_phase", 32'(bus.bomb_active) + 32'(bus.exp_active) + 32'(bus.post_exp_active), 1);
            if (prev_stall) begin
                chk("stall_we", bus.blk_we, 1);
                chk("stall_addr", bus.blk_w_addr, prev_addr);
                chk("stall_exp", bus.exp_active, 1);
            end

            gnt = 1'b1;
            if (bus.blk_we) begin
                if (stall_left > 0) begin
                    gnt = 1'b0;
                    stall_left--;
                end else if (gmode == 2) begin
                    gnt = ($urandom_range(0, 2) != 0);
                end
                if (gnt) got_q.push_back(int'(bus.blk_w_addr));
                else     stalls++;
            end
            prev_stall     = bus.blk_we && !gnt;
            prev_addr      = bus.blk_w_addr;
            bus.blk_wr_gnt = gnt;
            bus.place_req  = (hmode == 1) || (hmode == 2 && $urandom_range(0, 3) == 0);
            bus.bm_col     = 6'($urandom_range(0, COLS - 1));
            bus.bm_row     = 5'($urandom_range(0, ROWS - 1));
            @(negedge clk);
        end
        bus.place_req  = 1'b0;
        bus.blk_wr_gnt = 1'b1;

        chk("timeout", 32'(cyc >= LOOP_BUDGET), 0);
        chk("idle_after", bus.busy, 0);
        chk("we_after", bus.blk_we, 0);
        chk("bomb_cyc", bomb_cyc, FUSE);
        chk("exp_start_cnt", starts, 1);
        chk("nwrites", got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            chk("waddr", got_q[i], exp_q[i]);
        chk("exp_cyc", exp_cyc, exp_q.size() + stalls + EXP);
        chk("post_cyc", post_cyc, POST);
    endtask

    // Reset while a write request is outstanding, then a clean bomb
    task automatic reset_mid_clear();
        int cyc = 0;
        bus.bm_col     = 6'd10;
        bus.bm_row     = 5'd3;
        bus.place_req  = 1'b1;
        bus.blk_wr_gnt = 1'b0;
        @(negedge clk);
        bus.place_req = 1'b0;
        while (bus.blk_we !== 1'b1 && cyc < LOOP_BUDGET) begin
            cyc++;
            @(negedge clk);
        end
        chk("reach_clear", bus.blk_we, 1);
        reset = 1'b1;
        #1;
        chk("rst_we", bus.blk_we, 0);
        chk("rst_exp", bus.exp_active, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_addr", bus.blk_w_addr, 0);
        @(negedge clk);
        reset = 1'b0;
        bus.blk_wr_gnt = 1'b1;
        @(negedge clk);
        run_bomb(10, 3, 0, 0);
    endtask

    initial begin
        reset          = 1'b1;
        bus.place_req  = 1'b0;
        bus.bm_col     = '0;
        bus.bm_row     = '0;
        bus.blk_wr_gnt = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_bomb_active", bus.bomb_active, 0);
        chk("rst_bomb_col", bus.bomb_col, 0);
        chk("rst_bomb_row", bus.bomb_row, 0);
        chk("rst_exp_active", bus.exp_active, 0);
        chk("rst_exp_start", bus.exp_start, 0);
        chk("rst_post", bus.post_exp_active, 0);
        chk("rst_blk_we", bus.blk_we, 0);
        chk("rst_blk_addr", bus.blk_w_addr, 0);
        chk("rst_busy0", bus.busy, 0);
        reset = 1'b0;
        @(negedge clk);

        run_bomb(5, 7, 0, 0);
        run_bomb(0, 0, 0, 0);
        run_bomb(32, 26, 0, 0);
        run_bomb(5, 7, 1, 0);
        run_bomb(12, 13, 0, 1);
        reset_mid_clear();

        for (int n = 0; n < 20; n++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run_bomb(int'($urandom_range(0, COLS - 1)), int'($urandom_range(0, ROWS - 1)),
                     int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
